// File: rtl/chirp_pkg.sv
// Shared types and constants for the chirp sample source: sample format,
// FSM states and the quarter-wave sine table generator.
package chirp_pkg;

  localparam int NDINT   = 3;
  localparam int NDFRAC  = 22;
  localparam int NPHASE  = 32;
  localparam int NLUT    = 10;
  localparam int NSAMPLE = NDINT + NDFRAC;

  typedef logic signed [NDINT-1:-NDFRAC] sample_t;
  typedef logic [NDFRAC:0]               rom_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } chirp_state_t;

  // One quarter-wave entry: round(2^NDFRAC * sin(pi*k / 2^(NLUT+1))), k = 0..2^NLUT.
  function automatic rom_word_t rom_entry(input int k);
    real x;
    x = (2.0 ** NDFRAC) * $sin(3.14159265358979323846 * k / (2.0 ** (NLUT + 1)));
    return rom_word_t'($rtoi(x + 0.5));
  endfunction

endpackage

// File: rtl/chirp_if.sv
// Control and sample-stream bundle between a chirp_source and its user.
interface chirp_if;
  import chirp_pkg::*;

  // start is a level sampled only while idle; abort beats start. dv_out is a
  // one-cycle strobe with no ready/back-pressure; d_out is valid on dv_out and holds otherwise.
  logic              start;
  logic              abort;
  logic [NPHASE-1:0] freq0;
  logic [NPHASE-1:0] rate;
  logic [31:0]       nsamp;
  logic              busy;
  logic              done;
  logic              dv_out;
  sample_t           d_out;

  modport master (
    output start, abort, freq0, rate, nsamp,
    input  busy, done, dv_out, d_out
  );

  modport slave (
    input  start, abort, freq0, rate, nsamp,
    output busy, done, dv_out, d_out
  );

endinterface

// File: rtl/chirp_sine_rom.sv
// Quadrant-folded quarter-wave sine lookup: registered ROM read, then a
// registered sign application. Two cycles from phase to sample.
module chirp_sine_rom
  import chirp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            phase_valid,
  input  logic            phase_last,
  input  logic [NLUT+1:0] phase,
  output logic            sample_valid,
  output logic            sample_done,
  output sample_t         sample
);

  localparam logic [NLUT:0] FULL = {1'b1, {NLUT{1'b0}}};

  rom_word_t rom [0:2**NLUT];

  for (genvar k = 0; k <= 2**NLUT; k++) begin : g_rom
    assign rom[k] = rom_entry(k);
  end

  logic [1:0]      quad;
  logic [NLUT-1:0] idx;
  logic [NLUT:0]   addr;

  assign quad = phase[NLUT+1 -: 2];
  assign idx  = phase[NLUT-1:0];
  // Odd quadrants read the table backwards; index 0 there maps to the peak entry.
  assign addr = quad[0] ? (FULL - {1'b0, idx}) : {1'b0, idx};

  rom_word_t mag;
  logic      neg;
  logic      s2_valid;
  logic      s2_last;
  sample_t   mag_ext;

  assign mag_ext = sample_t'({{(NDINT-1){1'b0}}, mag});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag          <= '0;
      neg          <= 1'b0;
      s2_valid     <= 1'b0;
      s2_last      <= 1'b0;
      sample_valid <= 1'b0;
      sample_done  <= 1'b0;
      sample       <= '0;
    end else begin
      s2_valid     <= phase_valid & ~flush;
      sample_valid <= s2_valid & ~flush;
      sample_done  <= s2_valid & s2_last & ~flush;
      if (phase_valid) begin
        mag     <= rom[addr];
        neg     <= quad[1];
        s2_last <= phase_last;
      end
      if (s2_valid && !flush) begin
        sample <= neg ? -mag_ext : mag_ext;
      end
    end
  end

endmodule

// File: rtl/chirp_source.sv
// Linear-FM sine sample source: phase and frequency accumulators stepped on a
// fixed cadence, feeding a folded sine ROM that drives the dv/d sample stream.
module chirp_source
  import chirp_pkg::*;
#(
  parameter int NCADENCE = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  chirp_if.slave       bus,
  output chirp_state_t state
);

  localparam int            CW       = (NCADENCE > 1) ? $clog2(NCADENCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCADENCE - 1);

  logic [CW-1:0]     cnt;
  logic [NPHASE-1:0] phase;
  logic [NPHASE-1:0] freq;
  logic [NPHASE-1:0] rate_q;
  logic [31:0]       nsamp_q;
  logic [31:0]       scount;
  logic              s1_valid;
  logic              s1_last;
  logic              busy_q;
  logic              tick;
  logic              last_tick;
  logic              dv;
  logic              done;
  sample_t           d;

  assign tick      = (state == RUN) && (cnt == CNT_LAST);
  assign last_tick = (nsamp_q != 32'd0) && ((scount + 32'd1) == nsamp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= '0;
      freq     <= '0;
      rate_q   <= '0;
      nsamp_q  <= '0;
      scount   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state   <= RUN;
              busy_q  <= 1'b1;
              freq    <= bus.freq0;
              rate_q  <= bus.rate;
              nsamp_q <= bus.nsamp;
              phase   <= '0;
              cnt     <= '0;
              scount  <= '0;
            end
          end
          RUN: begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            // The phase register itself is the first pipeline stage.
            if (tick) begin
              phase    <= phase + freq;
              freq     <= freq + rate_q;
              scount   <= scount + 32'd1;
              s1_valid <= 1'b1;
              s1_last  <= last_tick;
              if (last_tick) begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (done) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  chirp_sine_rom u_rom (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (bus.abort),
    .phase_valid  (s1_valid),
    .phase_last   (s1_last),
    .phase        (phase[NPHASE-1 -: NLUT+2]),
    .sample_valid (dv),
    .sample_done  (done),
    .sample       (d)
  );

  assign bus.busy   = busy_q;
  assign bus.done   = done;
  assign bus.dv_out = dv;
  assign bus.d_out  = d;

endmodule

// File: tb/tb_chirp_source.sv
// Bench for chirp_source: a Ncadence=7 and a Ncadence=1 instance run side by
// side and are checked against a closed-form chirp model.
module tb_chirp_source;
  import chirp_pkg::*;

  localparam int NCAD = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chirp_if bus0 ();
  chirp_if bus1 ();
  chirp_state_t state0;
  chirp_state_t state1;

  chirp_source #(.NCADENCE(NCAD)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .state(state0)
  );

  chirp_source #(.NCADENCE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state(state1)
  );

  typedef struct {
    int          k;
    logic [24:0] d;
    logic        done;
    logic        busy;
  } obs_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [24:0] exp_q[$];
  obs_t        obs0[$];
  obs_t        obs1[$];
  int          busy_fall [2];
  int          done_cnt  [2];
  logic [24:0] quad_exp  [4] = '{25'h0400000, 25'h0000000, 25'h1C00000, 25'h0000000};

  // Sample n (1-based) sits at phase n*freq0 + rate*n*(n-1)/2 modulo 2^32.
  function automatic logic [24:0] model_sample(input logic [31:0] f0, input logic [31:0] r, input int n);
    logic [63:0] ph64;
    logic [31:0] ph;
    int          q;
    int          i;
    int          k;
    int          mag;
    ph64 = 64'(n) * {32'b0, f0} + ((64'(n) * 64'(n - 1)) / 64'd2) * {32'b0, r};
    ph   = ph64[31:0];
    q    = int'(ph[31:30]);
    i    = int'(ph[29:20]);
    k    = (q % 2 == 1) ? (1024 - i) : i;
    mag  = $rtoi(4194304.0 * $sin(3.141592653589793 * k / 2048.0) + 0.5);
    return (q >= 2) ? 25'(-mag) : 25'(mag);
  endfunction

  task automatic set_inputs(input logic s, input logic a, input logic [31:0] f, input logic [31:0] r, input logic [31:0] n);
    bus0.start = s; bus0.abort = a; bus0.freq0 = f; bus0.rate = r; bus0.nsamp = n;
    bus1.start = s; bus1.abort = a; bus1.freq0 = f; bus1.rate = r; bus1.nsamp = n;
  endtask

  // Starts a run on both instances and records every strobe, done pulse and busy fall.
  task automatic drive_run(input logic [31:0] f0, input logic [31:0] r, input logic [31:0] n,
                           input int ncyc, input int abort_k, input int stray_k);
    logic        dv_s   [2];
    logic        done_s [2];
    logic        busy_s [2];
    logic [24:0] d_s    [2];
    obs_t        ob;
    obs0.delete();
    obs1.delete();
    busy_fall = '{-1, -1};
    done_cnt  = '{0, 0};
    @(negedge clk);
    set_inputs(1'b1, 1'b0, f0, r, n);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      dv_s[0] = bus0.dv_out; done_s[0] = bus0.done; busy_s[0] = bus0.busy; d_s[0] = bus0.d_out;
      dv_s[1] = bus1.dv_out; done_s[1] = bus1.done; busy_s[1] = bus1.busy; d_s[1] = bus1.d_out;
      for (int u = 0; u < 2; u++) begin
        if (dv_s[u]) begin
          ob.k = k; ob.d = d_s[u]; ob.done = done_s[u]; ob.busy = busy_s[u];
          if (u == 0) obs0.push_back(ob); else obs1.push_back(ob);
        end
        if (done_s[u]) done_cnt[u]++;
        if (busy_fall[u] < 0 && !busy_s[u]) busy_fall[u] = k;
      end
      if (k == stray_k) set_inputs(1'b1, 1'b0, ~f0, ~r, 32'd1);
      else if (k == abort_k) set_inputs(1'b0, 1'b1, f0, r, n);
      else set_inputs(1'b0, 1'b0, f0, r, n);
    end
  endtask

  task automatic test_reset();
    logic        dv_a [2];
    logic        bz_a [2];
    logic        dn_a [2];
    logic [24:0] d_a  [2];
    chirp_state_t st_a [2];
    int          dv_seen;
    set_inputs(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    dv_a[0] = bus0.dv_out; bz_a[0] = bus0.busy; dn_a[0] = bus0.done; d_a[0] = bus0.d_out; st_a[0] = state0;
    dv_a[1] = bus1.dv_out; bz_a[1] = bus1.busy; dn_a[1] = bus1.done; d_a[1] = bus1.d_out; st_a[1] = state1;
    for (int u = 0; u < 2; u++) begin
      n_checks++; if (dv_a[u] !== 1'b0) $display("FAIL reset_dv u%0d: got %b want 0", u, dv_a[u]); else n_pass++;
      n_checks++; if (bz_a[u] !== 1'b0) $display("FAIL reset_busy u%0d: got %b want 0", u, bz_a[u]); else n_pass++;
      n_checks++; if (dn_a[u] !== 1'b0) $display("FAIL reset_done u%0d: got %b want 0", u, dn_a[u]); else n_pass++;
      n_checks++; if (d_a[u] !== 25'h0) $display("FAIL reset_d u%0d: got %h want 0", u, d_a[u]); else n_pass++;
      n_checks++; if (st_a[u] !== IDLE) $display("FAIL reset_state u%0d: got %0d want %0d", u, st_a[u], IDLE); else n_pass++;
    end
    rst_n = 1'b1;
    dv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      dv_seen += int'(bus0.dv_out) + int'(bus1.dv_out) + int'(bus0.busy) + int'(bus1.busy);
    end
    n_checks++; if (dv_seen !== 0) $display("FAIL idle_quiet: got %0d active cycles want 0", dv_seen); else n_pass++;
  endtask

  task automatic test_sequences();
    logic [31:0] f0;
    logic [31:0] r;
    int          nn;
    int          c;
    for (int tc = 0; tc < 7; tc++) begin
      exp_q.delete();
      case (tc)
        0: begin
          f0 = 32'h4000_0000; r = 32'd0; nn = 4;
          for (int j = 0; j < 4; j++) exp_q.push_back(quad_exp[j]);
        end
        1: begin
          f0 = 32'd0; r = 32'h0010_0000; nn = 3;
          exp_q.push_back(25'd0); exp_q.push_back(25'd6434); exp_q.push_back(25'd19302);
        end
        2: begin
          f0 = 32'hC000_0000; r = 32'd0; nn = 2;
          exp_q.push_back(25'h1C00000); exp_q.push_back(25'h0000000);
        end
        default: begin
          f0 = $urandom; r = $urandom; nn = $urandom_range(1, 12);
          for (int j = 1; j <= nn; j++) exp_q.push_back(model_sample(f0, r, j));
        end
      endcase
      drive_run(f0, r, 32'(nn), 7 * nn + 12, -1, -1);
      for (int u = 0; u < 2; u++) begin
        obs_t o[$];
        c = (u == 0) ? NCAD : 1;
        if (u == 0) o = obs0; else o = obs1;
        n_checks++;
        if (o.size() !== nn) $display("FAIL seq%0d_count u%0d: got %0d want %0d", tc, u, o.size(), nn);
        else n_pass++;
        for (int j = 0; j < o.size() && j < nn; j++) begin
          n_checks++;
          if (o[j].k !== c + 2 + c * j) $display("FAIL seq%0d_cycle u%0d s%0d: got %0d want %0d", tc, u, j, o[j].k, c + 2 + c * j);
          else n_pass++;
          n_checks++;
          if (o[j].d !== exp_q[j]) $display("FAIL seq%0d_sample u%0d s%0d: got %h want %h", tc, u, j, o[j].d, exp_q[j]);
          else n_pass++;
          n_checks++;
          if (o[j].done !== (j == nn - 1)) $display("FAIL seq%0d_done u%0d s%0d: got %b want %b", tc, u, j, o[j].done, (j == nn - 1));
          else n_pass++;
          n_checks++;
          if (o[j].busy !== 1'b1) $display("FAIL seq%0d_busy u%0d s%0d: got %b want 1", tc, u, j, o[j].busy);
          else n_pass++;
        end
        n_checks++;
        if (busy_fall[u] !== c * nn + 3) $display("FAIL seq%0d_busy_fall u%0d: got %0d want %0d", tc, u, busy_fall[u], c * nn + 3);
        else n_pass++;
        n_checks++;
        if (done_cnt[u] !== 1) $display("FAIL seq%0d_done_count u%0d: got %0d want 1", tc, u, done_cnt[u]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort_continuous();
    logic [31:0] f0;
    logic [31:0] r;
    int          want_n [2];
    int          c;
    int          active;
    f0 = $urandom;
    r  = $urandom;
    exp_q.delete();
    for (int j = 1; j <= 45; j++) exp_q.push_back(model_sample(f0, r, j));
    // Abort sampled on edge 41: between strobes 5 and 6 of the slow unit.
    drive_run(f0, r, 32'd0, 60, 40, 20);
    want_n = '{5, 38};
    for (int u = 0; u < 2; u++) begin
      obs_t o[$];
      c = (u == 0) ? NCAD : 1;
      if (u == 0) o = obs0; else o = obs1;
      n_checks++;
      if (o.size() !== want_n[u]) $display("FAIL abort_count u%0d: got %0d want %0d", u, o.size(), want_n[u]);
      else n_pass++;
      for (int j = 0; j < o.size() && j < want_n[u]; j++) begin
        n_checks++;
        if (o[j].k !== c + 2 + c * j || o[j].d !== exp_q[j])
          $display("FAIL abort_stream u%0d s%0d: got k=%0d d=%h want k=%0d d=%h", u, j, o[j].k, o[j].d, c + 2 + c * j, exp_q[j]);
        else n_pass++;
      end
      n_checks++;
      if (done_cnt[u] !== 0) $display("FAIL abort_done u%0d: got %0d pulses want 0", u, done_cnt[u]); else n_pass++;
      n_checks++;
      if (busy_fall[u] !== 41) $display("FAIL abort_busy_fall u%0d: got %0d want 41", u, busy_fall[u]); else n_pass++;
    end
    n_checks++;
    if (bus0.d_out !== exp_q[4]) $display("FAIL abort_hold u0: got %h want %h", bus0.d_out, exp_q[4]); else n_pass++;
    n_checks++;
    if (bus1.d_out !== exp_q[37]) $display("FAIL abort_hold u1: got %h want %h", bus1.d_out, exp_q[37]); else n_pass++;
    n_checks++;
    if (state0 !== IDLE || state1 !== IDLE) $display("FAIL abort_state: got %0d/%0d want %0d", state0, state1, IDLE); else n_pass++;
    // start together with abort in IDLE must leave the block idle.
    @(negedge clk);
    set_inputs(1'b1, 1'b1, 32'h4000_0000, 32'd0, 32'd4);
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 32'h4000_0000, 32'd0, 32'd4);
    active = 0;
    repeat (12) begin
      @(negedge clk);
      active += int'(bus0.dv_out) + int'(bus1.dv_out) + int'(bus0.busy) + int'(bus1.busy);
    end
    n_checks++;
    if (active !== 0) $display("FAIL start_abort_idle: got %0d active cycles want 0", active); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int active;
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 32'h4000_0000, 32'd0, 32'd4);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      set_inputs(1'b0, 1'b0, 32'h4000_0000, 32'd0, 32'd4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.dv_out !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.d_out !== 25'h0 || state0 !== IDLE)
      $display("FAIL midrun_reset u0: got dv=%b busy=%b done=%b d=%h st=%0d want all 0", bus0.dv_out, bus0.busy, bus0.done, bus0.d_out, state0);
    else n_pass++;
    n_checks++;
    if (bus1.dv_out !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.d_out !== 25'h0 || state1 !== IDLE)
      $display("FAIL midrun_reset u1: got dv=%b busy=%b done=%b d=%h st=%0d want all 0", bus1.dv_out, bus1.busy, bus1.done, bus1.d_out, state1);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    active = 0;
    repeat (20) begin
      @(negedge clk);
      active += int'(bus0.dv_out) + int'(bus1.dv_out);
    end
    n_checks++;
    if (active !== 0) $display("FAIL midrun_quiet: got %0d strobes want 0", active); else n_pass++;
    drive_run(32'h4000_0000, 32'd0, 32'd4, 40, -1, -1);
    n_checks++;
    if (obs0.size() !== 4 || obs1.size() !== 4) $display("FAIL midrun_rerun_count: got %0d/%0d want 4/4", obs0.size(), obs1.size());
    else n_pass++;
    for (int j = 0; j < 4 && j < obs0.size() && j < obs1.size(); j++) begin
      n_checks++;
      if (obs0[j].d !== quad_exp[j] || obs0[j].k !== NCAD + 2 + NCAD * j || obs1[j].d !== quad_exp[j])
        $display("FAIL midrun_rerun s%0d: got k=%0d d=%h/%h want k=%0d d=%h", j, obs0[j].k, obs0[j].d, obs1[j].d, NCAD + 2 + NCAD * j, quad_exp[j]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt[0] !== 1 || done_cnt[1] !== 1) $display("FAIL midrun_rerun_done: got %0d/%0d want 1/1", done_cnt[0], done_cnt[1]);
    else n_pass++;
  endtask

  initial begin
    set_inputs(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_sequences();
    test_abort_continuous();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chirp_source.md
Name: chirp_source

Overview:
- Hardware sample source for the IIR filter input. Drives the same dv/d strobe protocol the filter consumes: a single-cycle dv strobe with an Ndint.Ndfrac signed sample.
- Generates a linear-FM sine (chirp) using a phase accumulator, a frequency accumulator and a quarter-wave sine ROM.
- Used for on-chip filter characterisation and loopback; its dv_out/d_out connect directly to the filter's dv_in/d_in.

Parameters:
- Ndint, 3, integer bits of d_out (signed, includes sign).
- Ndfrac, 22, fractional bits of d_out.
- Nphase, 32, phase/frequency/rate accumulator width; full circle = 2^Nphase.
- Nlut, 10, quarter-wave ROM address bits; ROM holds 2^Nlut+1 entries.
- Ncadence, 7, clocks between output strobes; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  end the run immediately; takes priority over everything except reset.
- freq0  in  Nphase  signed initial phase increment per sample, latched on start.
- rate  in  Nphase  signed increment added to freq per sample, latched on start.
- nsamp  in  32  samples to emit; 0 = continuous until abort. Latched on start.
- busy  out  1  run in progress.
- done  out  1  single-cycle pulse with the last sample.
- dv_out  out  1  sample strobe, single cycle.
- d_out  out  [Ndint-1:-Ndfrac]  signed sample; holds between strobes.

Behaviour:
- **Reset.** dv_out=0, d_out=0, busy=0, done=0, state=IDLE. Phase, freq, rate, the cadence counter, the sample counter and the pipeline valids are all cleared. Reset mid-run aborts everything; no strobe appears after reset release until a new start.
- **States.**
  - IDLE: on start go to RUN. Latch freq0/rate/nsamp, phase=0, cadence cnt=0, busy=1 from the next cycle.
  - RUN: cnt increments each clock and wraps to 0 at Ncadence-1. tick = (cnt==Ncadence-1).
  - On each tick: phase <= phase+freq and freq <= freq+rate, both using the old freq. The sample counter increments. When the counter reaches nsamp (nsamp != 0), go to DRAIN and issue no further ticks.
  - DRAIN: wait for the pipeline to empty, then go to IDLE.
- **Arithmetic.** Phase and freq wrap modulo 2^Nphase (two's complement), with no saturation. The first emitted sample is sin(2π·freq0/2^Nphase).
- **ROM addressing.**
  - q = phase[Nphase-1:Nphase-2]; i = phase[Nphase-3 -: Nlut], truncated with no rounding or dither.
  - ROM[k] = round(2^Ndfrac·sin(πk/2^(Nlut+1))), k = 0..2^Nlut, unsigned Ndfrac+1 bits.
  - q0 → +ROM[i]; q1 → +ROM[2^Nlut-i]; q2 → -ROM[i]; q3 → -ROM[2^Nlut-i]. -0 = 0.
  - The result is sign-extended to Ndint+Ndfrac bits.
- **Pipeline.** Stage 1 registers phase (the tick edge). Stage 2 registers the ROM read plus the quadrant. Stage 3 applies the negation and registers d_out/dv_out.
- **Latency.**
  - dv_out first rises Ncadence+2 cycles after the edge that sampled start.
  - After that, dv_out rises exactly every Ncadence cycles.
  - With Ncadence=1, dv_out is high continuously.
- **done/busy.** done is asserted in the same cycle as the nsamp-th dv_out. busy falls on the following cycle. With nsamp=0, done never fires.
- **start handling.** start while busy is ignored. start and abort together in IDLE: abort wins and the block stays in IDLE.
- **abort.** When abort is sampled, go to IDLE and clear the pipeline valids, so dv_out=0 from the next cycle on. done is not pulsed, busy=0 from the next cycle, and d_out holds its last value.

Decomposition:
- Package chirp_pkg holds:
  - the sample typedef (signed [Ndint-1:-Ndfrac]);
  - the state enum {IDLE, RUN, DRAIN};
  - a constant function that builds the quarter-wave ROM from Nlut/Ndfrac at elaboration.
- One sub-module, chirp_sine_rom: quadrant-folded registered lookup, phase in, signed sample out, 2-cycle latency.

Test Plan:
- Quadrant exactness. Setup: Ndint=3, Ndfrac=22, Nphase=32, Nlut=10, Ncadence=7, freq0=2^30, rate=0, nsamp=4. Expect d_out = 25'h0400000, 25'h0000000, 25'h1C00000, 25'h0000000. done is high with the 4th strobe; busy falls one cycle later.
- Cadence and latency. Same run: the first dv_out is 9 cycles after the start edge, strobes are spaced exactly 7 cycles, and each strobe is 1 cycle wide. With Ncadence=1, expect 4 consecutive dv_out cycles.
- Chirp accumulation. freq0=0, rate=2^20, nsamp=3. Expect samples 0, ROM[1]=6434, ROM[3]=19302 (= round(2^22·sin(3π/2048))).
- Negative frequency and wrap. freq0=-2^30, rate=0, nsamp=2. Expect 25'h1C00000 then 25'h0000000.
- Continuous and abort. nsamp=0; assert abort for 1 cycle between strobes 5 and 6. Expect no further dv_out, done never high, busy low the next cycle, d_out holding sample 5. A start while busy earlier in the run has no effect.
- Reset mid-run. Drop rst_n asynchronously mid-cycle during RUN. Expect all outputs 0 immediately; after release, no dv_out until a new start, and that run reproduces the first scenario's sequence exactly.
